// File: rtl/mips_regfile_if.sv
// Bus bundle for mips_regfile: writeback write port, two decode read ports
// and the valid/ready register dump port.
interface mips_regfile_if #(
    parameter int W = 32
);
    logic         we;
    logic [4:0]   waddr;
    logic [W-1:0] wdata;
    logic [4:0]   raddr1;
    logic [4:0]   raddr2;
    logic [W-1:0] rdata1;
    logic [W-1:0] rdata2;
    logic         dump_start;
    logic         dump_ready;
    logic         dump_valid;
    logic [4:0]   dump_idx;
    logic [W-1:0] dump_data;
    logic         dump_busy;
    logic         dump_done;

    modport master (
        output we, waddr, wdata, raddr1, raddr2, dump_start, dump_ready,
        input  rdata1, rdata2, dump_valid, dump_idx, dump_data, dump_busy, dump_done
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, dump_start, dump_ready,
        output rdata1, rdata2, dump_valid, dump_idx, dump_data, dump_busy, dump_done
    );
endinterface

// File: rtl/mips_regfile.sv
// 32x32 MIPS register file ($0 hardwired to zero) with a valid/ready dump engine.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module mips_regfile #(
    parameter int W = 32,
    parameter int N = 32
) (
    input logic           clk,
    input logic           rst,
    mips_regfile_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHOW
    } dump_state_e;

    logic [W-1:0] regs_q [N];
    logic [W-1:0] regs_d [N];
    dump_state_e  state_q, state_d;
    logic [4:0]   idx_q, idx_d;
    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    always_comb begin
        regs_d = regs_q;
        if (bus.we && (bus.waddr != 5'd0)) begin
            regs_d[bus.waddr] = bus.wdata;
        end
    end

    always_comb begin
        bus.rdata1 = (bus.raddr1 == 5'd0) ? '0 : regs_q[bus.raddr1];
        bus.rdata2 = (bus.raddr2 == 5'd0) ? '0 : regs_q[bus.raddr2];
`ifdef REGFILE_BYPASS_EN
        if (bus.we && (bus.waddr != 5'd0) && (bus.waddr == bus.raddr1)) begin
            bus.rdata1 = bus.wdata;
        end
        if (bus.we && (bus.waddr != 5'd0) && (bus.waddr == bus.raddr2)) begin
            bus.rdata2 = bus.wdata;
        end
`endif
    end

    // Capture reads regs_q, not the bypass path, so a coincident write never leaks in.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.dump_start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                data_d  = regs_q[idx_q];
                state_d = SHOW;
            end
            SHOW: begin
                if (valid_q && bus.dump_ready) begin
                    if (idx_q == 5'd31) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LOAD;
                        idx_d   = idx_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == SHOW);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                regs_q[i] <= '0;
            end
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.dump_valid = valid_q;
    assign bus.dump_idx   = idx_q;
    assign bus.dump_data  = data_q;
    assign bus.dump_busy  = busy_q;
    assign bus.dump_done  = done_q;
endmodule
